pc_branch_unit: RTL and testbench
=================================

# pc_branch_unit

Program-counter register and branch-redirect stage for the 16-bit processor. It consumes the registered, word-shifted branch offset from the shift-left stage (`slOut`), which arrives one cycle after the branch is decoded. It adds that offset to the sequential PC of the branch and drives the fetch address. A three-state FSM absorbs the one-cycle offset latency and pipeline stalls, and emits a one-cycle redirect/flush pulse toward fetch and decode.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `PC_INC`, default 16'd4: sequential increment per fetched instruction.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous active-high reset.
- `stall`  in  1  pipeline stall; freezes PC advance.
- `branch_req`  in  1  branch instruction decoded this cycle; sampled only when `stall`=0 in RUN.
- `branch_taken`  in  1  branch condition; sampled together with `branch_req`.
- `slOut`  in  16  shifted branch offset, two's complement; valid in the cycle after an accepted `branch_req`.
- `pc`  out  16  current fetch address.
- `pc_plus`  out  16  `pc + PC_INC`, combinational.
- `redirect`  out  1  registered one-cycle pulse: `pc` was just loaded with a taken-branch target.
- `flush`  out  1  registered one-cycle pulse, identical in timing to `redirect`; kills wrong-path instructions.
- `busy`  out  1  high while state is not RUN.

## Operation
- Reset values: `pc`=`RESET_PC`, state=RUN, `redirect`=0, `flush`=0, `busy`=0, internal base/target/taken registers=0.
- RUN:
  - `stall`=1: hold `pc`; `branch_req` is ignored, so upstream must hold it.
  - `stall`=0 and `branch_req`=0: `pc` <= `pc + PC_INC`.
  - `stall`=0 and `branch_req`=1: `base` <= `pc + PC_INC`, latch `branch_taken`, hold `pc`, go to WAIT.
- WAIT: sample `slOut` unconditionally and form `target` = taken ? `base + slOut` : `base`.
  - `stall`=0: `pc` <= `target`; `redirect`/`flush` <= taken; go to RUN.
  - `stall`=1: store `target`, go to APPLY.
- APPLY: hold until `stall`=0, then `pc` <= stored target, `redirect`/`flush` <= latched taken, go to RUN.
- Arithmetic: all 16-bit, modulo 2^16; carries are discarded, so wrap-around is silent.
- `branch_req` in WAIT or APPLY is ignored.
- `redirect` and `flush` are deasserted in every cycle not immediately following a taken update.
- `rst` in any state: pending branch is discarded, reset values apply at that edge, and no redirect pulse is issued.

## Timing
- Branch accepted at edge E0, state enters WAIT. `slOut` is valid in the cycle after E0; `pc` = target after edge E1; `redirect`=1 for exactly that one cycle.
- Taken-branch penalty is one held cycle plus the flush, with no stall.
- Each stall cycle in WAIT or APPLY adds one cycle of latency. The offset is never re-sampled after WAIT.
- Sequential fetch throughput is one `PC_INC` step per non-stalled cycle.

## Configuration
- `PC_BRANCH_STATS_EN` defined:
  - Adds output port `branch_count` (out, 16 bits), reset value 0.
  - Increments once per taken redirect and saturates at 16'hFFFF.
- `PC_BRANCH_STATS_EN` undefined: the port and counter do not exist, and all other behaviour is identical.

## Structure
- Shared package `pc_branch_pkg`:
  - PC width constant (16).
  - Default `PC_INC`.
  - State typedef with values RUN, WAIT, APPLY.
- One natural sub-module, `branch_target_adder`: combinational, computes `base + slOut`; it is reused by the jump path later.
- FSM, PC register and pulse registers live in the top.

## Test plan
- Reset with `RESET_PC`=16'h0100, no branches, 3 cycles -> `pc` = 0100, 0104, 0108, 010C; `redirect`=0 throughout.
- `pc`=0x0010, `branch_req`=1 with `branch_taken`=1, `slOut`=0x0020 next cycle -> `pc` = 0x0034 after WAIT; `redirect`=`flush`=1 for one cycle; `busy`=1 during WAIT only.
- Same as above with `branch_taken`=0 -> `pc` = 0x0014, no redirect pulse.
- `pc`=0xFFF8, taken, `slOut`=0x0010 -> `pc` = 0x000C (wrap). Separately, `pc`=0x0040, taken, `slOut`=0xFFE0 -> `pc` = 0x0024 (negative offset).
- Taken branch with `stall`=1 asserted in WAIT for 3 cycles and `slOut` changing after WAIT -> target uses the WAIT-cycle `slOut`; the update and redirect occur in the cycle after `stall` falls.
- `rst` asserted while in APPLY -> `pc`=`RESET_PC`, state RUN, no redirect. With `PC_BRANCH_STATS_EN` defined, `branch_count` returns to 0, and after 3 taken branches reads 3.

Source files
------------

// File: rtl/pc_branch_pkg.sv
// Shared types and constants for the PC register / branch-redirect stage.
package pc_branch_pkg;

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] PC_INC_DEFAULT = 16'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    APPLY = 2'd2
  } pc_state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Combinational branch target adder: base + two's-complement offset, modulo 2^PC_W.
module branch_target_adder
  import pc_branch_pkg::*;
(
  input  logic [PC_W-1:0] base,
  input  logic [PC_W-1:0] offset,
  output logic [PC_W-1:0] sum_c
);

  assign sum_c = base + offset;

endmodule

// File: rtl/pc_branch_unit.sv
// PC register and branch-redirect FSM; absorbs the one-cycle offset latency and stalls.
// Optional: define PC_BRANCH_STATS_EN to add a saturating taken-redirect counter (branch_count).
module pc_branch_unit
  import pc_branch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [PC_W-1:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_req,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] slOut,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus,
  output logic            redirect,
  output logic            flush,
  output logic            busy
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [PC_W-1:0] branch_count
`endif
);

  pc_state_e       state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [PC_W-1:0] base_q, base_n;
  logic [PC_W-1:0] target_q, target_n;
  logic            taken_q, taken_n;
  logic            redir_n;
  logic [PC_W-1:0] sum_c;
  logic [PC_W-1:0] wait_target_c;

  assign pc_plus = pc + PC_INC;

  branch_target_adder u_adder (
    .base   (base_q),
    .offset (slOut),
    .sum_c  (sum_c)
  );

  // Target formed from the offset sampled in WAIT; not-taken falls through to base.
  assign wait_target_c = taken_q ? sum_c : base_q;

  // Next-state and datapath selection.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    base_n   = base_q;
    target_n = target_q;
    taken_n  = taken_q;
    redir_n  = 1'b0;
    case (state)
      RUN: begin
        if (!stall) begin
          if (branch_req) begin
            base_n  = pc_plus;
            taken_n = branch_taken;
            state_n = WAIT;
          end else begin
            pc_n = pc_plus;
          end
        end
      end
      WAIT: begin
        if (!stall) begin
          pc_n    = wait_target_c;
          redir_n = taken_q;
          state_n = RUN;
        end else begin
          target_n = wait_target_c;
          state_n  = APPLY;
        end
      end
      APPLY: begin
        if (!stall) begin
          pc_n    = target_q;
          redir_n = taken_q;
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      base_q   <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
      redirect <= 1'b0;
      flush    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      base_q   <= base_n;
      target_q <= target_n;
      taken_q  <= taken_n;
      redirect <= redir_n;
      flush    <= redir_n;
      busy     <= (state_n != RUN);
    end
  end

`ifdef PC_BRANCH_STATS_EN
  // Saturating count of taken redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count <= '0;
    end else if (redir_n && (branch_count != {PC_W{1'b1}})) begin
      branch_count <= branch_count + PC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit with a pending-branch reference model checked every cycle.
module tb_pc_branch_unit;

  localparam logic [15:0] RST_PC = 16'h0100;
  localparam logic [15:0] INC    = 16'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_req = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] slOut = 16'h0000;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic        redirect;
  logic        flush;
  logic        busy;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] branch_count;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  pc_branch_unit #(.RESET_PC(RST_PC), .PC_INC(INC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_req   (branch_req),
    .branch_taken (branch_taken),
    .slOut        (slOut),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .redirect     (redirect),
    .flush        (flush),
    .busy         (busy)
`ifdef PC_BRANCH_STATS_EN
    ,
    .branch_count (branch_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a fetch PC plus at most one pending branch record.
  logic [15:0] m_pc = RST_PC;
  logic        m_redir = 1'b0;
  logic        m_busy = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_have = 1'b0;
  bit          m_tk = 1'b0;
  logic [15:0] m_base = 16'h0000;
  logic [15:0] m_tgt = 16'h0000;
  logic [15:0] m_cnt = 16'h0000;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = RST_PC; m_redir = 1'b0; m_busy = 1'b0;
      m_pend = 1'b0; m_have = 1'b0; m_cnt = 16'h0000;
    end else begin
      m_redir = 1'b0;
      if (!m_pend) begin
        if (!stall) begin
          if (branch_req) begin
            m_pend = 1'b1; m_have = 1'b0;
            m_base = m_pc + INC; m_tk = branch_taken;
          end else begin
            m_pc = m_pc + INC;
          end
        end
      end else begin
        if (!m_have) begin
          m_tgt = m_tk ? m_base + slOut : m_base;
          m_have = 1'b1;
        end
        if (!stall) begin
          m_pc = m_tgt;
          m_redir = m_tk;
          m_pend = 1'b0;
          if (m_tk && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      m_busy = m_pend;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("pc_plus", pc_plus, m_pc + INC);
      check("redirect", {15'd0, redirect}, {15'd0, m_redir});
      check("flush", {15'd0, flush}, {15'd0, m_redir});
      check("busy", {15'd0, busy}, {15'd0, m_busy});
`ifdef PC_BRANCH_STATS_EN
      check("branch_count", branch_count, m_cnt);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Steer pc to dst with a taken branch; returns at the redirect cycle, inputs idle.
  task automatic goto_pc(input logic [15:0] dst);
    logic [15:0] base;
    base = m_pc + INC;
    branch_req = 1'b1; branch_taken = 1'b1;
    step(1);
    branch_req = 1'b0; branch_taken = 1'b0;
    slOut = dst - base;
    step(1);
    check("goto_pc", pc, dst);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_pc", pc, 16'h0100);
    check("reset_busy", {15'd0, busy}, 16'd0);
    step(1); check("seq1", pc, 16'h0104);
    step(1); check("seq2", pc, 16'h0108);
    step(1); check("seq3", pc, 16'h010C);
    check("seq_redir", {15'd0, redirect}, 16'd0);

    // Taken branch from 0x0010 with offset 0x0020.
    goto_pc(16'h0010);
    branch_req = 1'b1; branch_taken = 1'b1;
    step(1);
    check("tk_wait_busy", {15'd0, busy}, 16'd1);
    check("tk_wait_pc", pc, 16'h0010);
    branch_req = 1'b0; branch_taken = 1'b0; slOut = 16'h0020;
    step(1);
    check("tk_pc", pc, 16'h0034);
    check("tk_redir", {15'd0, redirect}, 16'd1);
    check("tk_flush", {15'd0, flush}, 16'd1);
    check("tk_busy", {15'd0, busy}, 16'd0);
    step(1);
    check("tk_redir_off", {15'd0, redirect}, 16'd0);
    check("tk_next", pc, 16'h0038);

    // Not-taken branch falls through.
    goto_pc(16'h0010);
    branch_req = 1'b1; branch_taken = 1'b0;
    step(1);
    branch_req = 1'b0; slOut = 16'h0020;
    step(1);
    check("nt_pc", pc, 16'h0014);
    check("nt_redir", {15'd0, redirect}, 16'd0);

    // Wrap-around and negative offset.
    goto_pc(16'hFFF8);
    branch_req = 1'b1; branch_taken = 1'b1;
    step(1);
    branch_req = 1'b0; branch_taken = 1'b0; slOut = 16'h0010;
    step(1);
    check("wrap_pc", pc, 16'h000C);
    goto_pc(16'h0040);
    branch_req = 1'b1; branch_taken = 1'b1;
    step(1);
    branch_req = 1'b0; branch_taken = 1'b0; slOut = 16'hFFE0;
    step(1);
    check("neg_pc", pc, 16'h0024);

    // Stall in WAIT for three cycles; offset changes after WAIT; stray req ignored.
    goto_pc(16'h0200);
    branch_req = 1'b1; branch_taken = 1'b1;
    step(1);
    branch_taken = 1'b0; stall = 1'b1; slOut = 16'h0040;
    step(1);
    slOut = 16'h1111;
    step(2);
    check("stall_pc", pc, 16'h0200);
    check("stall_busy", {15'd0, busy}, 16'd1);
    check("stall_redir", {15'd0, redirect}, 16'd0);
    branch_req = 1'b0; stall = 1'b0;
    step(1);
    check("stall_tgt", pc, 16'h0244);
    check("stall_pulse", {15'd0, redirect}, 16'd1);
    step(1);
    check("stall_after", pc, 16'h0248);

    // Reset while in APPLY discards the branch.
    goto_pc(16'h0300);
    branch_req = 1'b1; branch_taken = 1'b1;
    step(1);
    branch_req = 1'b0; branch_taken = 1'b0; stall = 1'b1; slOut = 16'h0004;
    step(1);
    check("apply_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0; stall = 1'b0;
    check("rst_pc", pc, 16'h0100);
    check("rst_redir", {15'd0, redirect}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
`ifdef PC_BRANCH_STATS_EN
    check("rst_count", branch_count, 16'd0);
`endif
    step(1);
    check("rst_seq", pc, 16'h0104);
    check("rst_seq_redir", {15'd0, redirect}, 16'd0);

    goto_pc(16'h0400);
    goto_pc(16'h0500);
    goto_pc(16'h0600);
`ifdef PC_BRANCH_STATS_EN
    check("count3", branch_count, 16'd3);
`endif
    step(2);
    check("final_pc", pc, 16'h0608);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
